// File: rtl/w0rm_core_imem_fetch_if.sv
// Fetch-request and instruction-memory read-bus signals of the W0RM fetch unit.
// master: the fetch unit itself; slave: the fetch stage and memory side.
interface w0rm_core_imem_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WIDTH  = 32,
    parameter int INST_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_addr_valid;
    logic                  fetch_ready;
    logic                  flush;
    logic [INST_WIDTH-1:0] inst_data;
    logic                  inst_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_ready;
    logic [MEM_WIDTH-1:0]  mem_data;
    logic                  mem_data_valid;

    modport master (
        input  fetch_addr, fetch_addr_valid, flush, mem_ready, mem_data, mem_data_valid,
        output fetch_ready, inst_data, inst_valid, mem_addr, mem_read
    );

    modport slave (
        output fetch_addr, fetch_addr_valid, flush, mem_ready, mem_data, mem_data_valid,
        input  fetch_ready, inst_data, inst_valid, mem_addr, mem_read
    );
endinterface

// File: rtl/w0rm_core_imem_fetch.sv
// Instruction-memory fetch unit: one-word line buffer, single-outstanding
// 32-bit read bus, 16-bit halfword return with a one-cycle valid pulse.
module w0rm_core_imem_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WIDTH  = 32,
    parameter int INST_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    w0rm_core_imem_fetch_if.master     bus
);
    localparam int TAG_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t                state, state_d;
    logic                  line_valid, line_valid_d;
    logic [TAG_W-1:0]      line_tag, line_tag_d;
    logic [MEM_WIDTH-1:0]  line_data, line_data_d;
    logic                  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_read_q, mem_read_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [INST_WIDTH-1:0] inst_data_q, inst_data_d;

    logic                  fetch_ready;
    logic                  accept;
    logic [TAG_W-1:0]      req_tag;
    logic                  unused_addr_bit;

    // Byte bit of the PC is meaningless for halfword instructions.
    assign unused_addr_bit = bus.fetch_addr[0];

    assign fetch_ready = (state == IDLE) && !reset;
    assign accept      = bus.fetch_addr_valid && fetch_ready && !bus.flush;
    assign req_tag     = bus.fetch_addr[ADDR_WIDTH-1:2];

    assign bus.fetch_ready = fetch_ready;
    assign bus.inst_data   = inst_data_q;
    assign bus.inst_valid  = inst_valid_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_read    = mem_read_q;

    function automatic logic [INST_WIDTH-1:0] pick_half(input logic [MEM_WIDTH-1:0] word,
                                                        input logic sel);
        return sel ? word[2*INST_WIDTH-1:INST_WIDTH] : word[INST_WIDTH-1:0];
    endfunction

    // State and datapath registers, cleared synchronously on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            line_valid   <= 1'b0;
            line_tag     <= '0;
            line_data    <= '0;
            sel_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
        end else begin
            state        <= state_d;
            line_valid   <= line_valid_d;
            line_tag     <= line_tag_d;
            line_data    <= line_data_d;
            sel_q        <= sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
        end
    end

    // Next-state, line-buffer fill and instruction delivery.
    always_comb begin
        state_d      = state;
        line_valid_d = line_valid;
        line_tag_d   = line_tag;
        line_data_d  = line_data;
        sel_d        = sel_q;
        mem_addr_d   = mem_addr_q;
        mem_read_d   = mem_read_q;
        inst_valid_d = 1'b0;
        inst_data_d  = inst_data_q;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (line_valid && (req_tag == line_tag)) begin
                        inst_valid_d = 1'b1;
                        inst_data_d  = pick_half(line_data, bus.fetch_addr[1]);
                    end else begin
                        sel_d      = bus.fetch_addr[1];
                        mem_addr_d = {req_tag, 2'b00};
                        mem_read_d = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    mem_read_d = 1'b0;
                    // Data returned with the grant completes the read in one step.
                    if (bus.mem_data_valid) begin
                        line_valid_d = 1'b1;
                        line_tag_d   = mem_addr_q[ADDR_WIDTH-1:2];
                        line_data_d  = bus.mem_data;
                        state_d      = IDLE;
                        if (!bus.flush) begin
                            inst_valid_d = 1'b1;
                            inst_data_d  = pick_half(bus.mem_data, sel_q);
                        end
                    end else begin
                        state_d = bus.flush ? DROP : WAIT;
                    end
                end else if (bus.flush) begin
                    mem_read_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            WAIT: begin
                if (bus.mem_data_valid) begin
                    line_valid_d = 1'b1;
                    line_tag_d   = mem_addr_q[ADDR_WIDTH-1:2];
                    line_data_d  = bus.mem_data;
                    state_d      = IDLE;
                    if (!bus.flush) begin
                        inst_valid_d = 1'b1;
                        inst_data_d  = pick_half(bus.mem_data, sel_q);
                    end
                end else if (bus.flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.mem_data_valid) begin
                    line_valid_d = 1'b1;
                    line_tag_d   = mem_addr_q[ADDR_WIDTH-1:2];
                    line_data_d  = bus.mem_data;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_w0rm_core_imem_fetch.sv
// Directed bench for w0rm_core_imem_fetch with a queue-based scoreboard for
// returned instructions.
module tb_w0rm_core_imem_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e_exp;

    always #5 clk = ~clk;

    w0rm_core_imem_fetch_if #(.ADDR_WIDTH(32), .MEM_WIDTH(32), .INST_WIDTH(16)) bus ();

    w0rm_core_imem_fetch #(.ADDR_WIDTH(32), .MEM_WIDTH(32), .INST_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr);
        bus.fetch_addr       = addr;
        bus.fetch_addr_valid = 1'b1;
        step();
        bus.fetch_addr_valid = 1'b0;
    endtask

    // Monitor: every inst_valid pulse must match the oldest expected halfword.
    always @(negedge clk) begin
        if (bus.inst_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst actual=%h required=none", bus.inst_data);
            end else begin
                e_exp = exp_q.pop_front();
                check("inst_data", {16'h0, bus.inst_data}, {16'h0, e_exp});
            end
        end
    end

    initial begin
        bus.fetch_addr       = '0;
        bus.fetch_addr_valid = 1'b0;
        bus.flush            = 1'b0;
        bus.mem_ready        = 1'b0;
        bus.mem_data         = '0;
        bus.mem_data_valid   = 1'b0;

        // Reset values
        step();
        step();
        check("rst_fetch_ready", {31'h0, bus.fetch_ready}, 32'h0);
        check("rst_inst_valid",  {31'h0, bus.inst_valid},  32'h0);
        check("rst_inst_data",   {16'h0, bus.inst_data},   32'h0);
        check("rst_mem_read",    {31'h0, bus.mem_read},    32'h0);
        check("rst_mem_addr",    bus.mem_addr,             32'h0);
        reset = 1'b0;
        step();
        check("ready_after_rst", {31'h0, bus.fetch_ready}, 32'h1);

        // Miss to 0x2000_0000, data after 2 wait cycles
        request(32'h2000_0000);
        check("miss1_mem_read", {31'h0, bus.mem_read}, 32'h1);
        check("miss1_mem_addr", bus.mem_addr, 32'h2000_0000);
        check("miss1_ready",    {31'h0, bus.fetch_ready}, 32'h0);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        check("miss1_read_drop", {31'h0, bus.mem_read}, 32'h0);
        step();
        step();
        check("miss1_wait_ready", {31'h0, bus.fetch_ready}, 32'h0);
        bus.mem_data       = 32'hBBBB_AAAA;
        bus.mem_data_valid = 1'b1;
        exp_q.push_back(16'hAAAA);
        step();
        bus.mem_data_valid = 1'b0;
        check("miss1_valid", {31'h0, bus.inst_valid}, 32'h1);

        // Hit on upper halfword, then back-to-back hit on lower halfword
        exp_q.push_back(16'hBBBB);
        request(32'h2000_0002);
        check("hit_valid",    {31'h0, bus.inst_valid}, 32'h1);
        check("hit_mem_read", {31'h0, bus.mem_read},   32'h0);
        exp_q.push_back(16'hAAAA);
        request(32'h2000_0000);
        check("hit2_valid",   {31'h0, bus.inst_valid}, 32'h1);

        // Miss with mem_ready held low 3 cycles; grant and data same cycle
        request(32'h2000_0004);
        check("stall_mem_read", {31'h0, bus.mem_read}, 32'h1);
        check("stall_mem_addr", bus.mem_addr, 32'h2000_0004);
        check("stall_ready",    {31'h0, bus.fetch_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_mem_read", {31'h0, bus.mem_read}, 32'h1);
            check("stall_mem_addr", bus.mem_addr, 32'h2000_0004);
            check("stall_ready",    {31'h0, bus.fetch_ready}, 32'h0);
        end
        bus.mem_ready      = 1'b1;
        bus.mem_data       = 32'hDDDD_CCCC;
        bus.mem_data_valid = 1'b1;
        exp_q.push_back(16'hCCCC);
        step();
        bus.mem_ready      = 1'b0;
        bus.mem_data_valid = 1'b0;
        check("same_cycle_read_drop", {31'h0, bus.mem_read},   32'h0);
        check("same_cycle_valid",     {31'h0, bus.inst_valid}, 32'h1);

        // Flush in WAIT: line still filled, no instruction returned
        request(32'h2000_0010);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        check("drop_ready", {31'h0, bus.fetch_ready}, 32'h0);
        step();
        bus.mem_data       = 32'h1234_5678;
        bus.mem_data_valid = 1'b1;
        step();
        bus.mem_data_valid = 1'b0;
        check("drop_no_valid",  {31'h0, bus.inst_valid},  32'h0);
        check("drop_ready_end", {31'h0, bus.fetch_ready}, 32'h1);
        exp_q.push_back(16'h1234);
        request(32'h2000_0012);
        check("drop_hit_valid", {31'h0, bus.inst_valid}, 32'h1);
        check("drop_hit_read",  {31'h0, bus.mem_read},   32'h0);

        // Flush in REQ without grant: read abandoned, late data ignored
        request(32'h2000_0020);
        check("reqflush_read", {31'h0, bus.mem_read}, 32'h1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("reqflush_read_drop", {31'h0, bus.mem_read},    32'h0);
        check("reqflush_ready",     {31'h0, bus.fetch_ready}, 32'h1);
        bus.mem_data       = 32'hFFFF_EEEE;
        bus.mem_data_valid = 1'b1;
        step();
        bus.mem_data_valid = 1'b0;
        check("late_no_valid", {31'h0, bus.inst_valid}, 32'h0);
        request(32'h2000_0020);
        check("late_no_fill_read", {31'h0, bus.mem_read}, 32'h1);
        check("late_no_fill_addr", bus.mem_addr, 32'h2000_0020);
        bus.mem_ready      = 1'b1;
        bus.mem_data       = 32'h9999_8888;
        bus.mem_data_valid = 1'b1;
        exp_q.push_back(16'h8888);
        step();
        bus.mem_ready      = 1'b0;
        bus.mem_data_valid = 1'b0;

        // Refill 0x2000_0000, then reset during a WAIT clears the line
        request(32'h2000_0000);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready      = 1'b0;
        bus.mem_data       = 32'hBBBB_AAAA;
        bus.mem_data_valid = 1'b1;
        exp_q.push_back(16'hAAAA);
        step();
        bus.mem_data_valid = 1'b0;
        exp_q.push_back(16'hBBBB);
        request(32'h2000_0002);
        check("refill_hit_read", {31'h0, bus.mem_read}, 32'h0);
        request(32'h2000_0030);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_read",  {31'h0, bus.mem_read},   32'h0);
        check("midrst_valid", {31'h0, bus.inst_valid}, 32'h0);
        bus.mem_data       = 32'h5555_4444;
        bus.mem_data_valid = 1'b1;
        step();
        bus.mem_data_valid = 1'b0;
        check("midrst_late_valid", {31'h0, bus.inst_valid}, 32'h0);
        request(32'h2000_0000);
        check("postrst_miss_read", {31'h0, bus.mem_read}, 32'h1);
        check("postrst_miss_addr", bus.mem_addr, 32'h2000_0000);
        bus.mem_ready      = 1'b1;
        bus.mem_data       = 32'hBBBB_AAAA;
        bus.mem_data_valid = 1'b1;
        exp_q.push_back(16'hAAAA);
        step();
        bus.mem_ready      = 1'b0;
        bus.mem_data_valid = 1'b0;

        step();
        step();
        step();
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/w0rm_core_imem_fetch.md
Name: w0rm_core_imem_fetch

Overview:
- Instruction-memory fetch unit directly upstream of the W0RM instruction fetch stage.
- Accepts the fetch stage's PC request and reads 32-bit words from instruction memory over a single-outstanding read bus.
- Selects the 16-bit instruction halfword and returns it with a valid pulse.
- Keeps a one-word line buffer so sequential halfwords in the same word cost no bus cycle; branch flushes discard in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- MEM_WIDTH, 32, memory data width; only 32 supported.
- INST_WIDTH, 16, instruction width.

Ports:
- clk  input  1  core clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- fetch_addr  input  ADDR_WIDTH  requested instruction address (PC)
- fetch_addr_valid  input  1  fetch_addr is a request this cycle
- fetch_ready  output  1  unit can accept a request this cycle
- flush  input  1  branch flush; abandon current request
- inst_data  output  INST_WIDTH  fetched instruction
- inst_valid  output  1  one-cycle pulse, inst_data valid
- mem_addr  output  ADDR_WIDTH  word-aligned read address, bits [1:0]=0
- mem_read  output  1  read request, held until accepted
- mem_ready  input  1  memory accepts mem_read this cycle
- mem_data  input  MEM_WIDTH  read data
- mem_data_valid  input  1  read data returned this cycle

Behaviour:
- Reset values:
  - fetch_ready=0 during reset, 1 the cycle after.
  - inst_valid=0, inst_data=0, mem_read=0, mem_addr=0.
  - line_valid=0; state IDLE.
- States: IDLE, REQ, WAIT, DROP.
- fetch_ready=1 only in IDLE and not reset.
- A request is accepted when fetch_addr_valid && fetch_ready && !flush.
- Tag = fetch_addr[ADDR_WIDTH-1:2]. fetch_addr[0] ignored (treated 0).
- Halfword select (little-endian):
  - fetch_addr[1]=0 -> word[15:0].
  - fetch_addr[1]=1 -> word[31:16].
- IDLE, accept, hit (line_valid && tag==line_tag):
  - Next cycle inst_valid=1 with the selected halfword from line_data.
  - Stay IDLE, no bus activity.
  - Hit latency 1 cycle; back-to-back hits sustain one instruction per cycle.
- IDLE, accept, miss:
  - Latch the select bit.
  - Next cycle: mem_addr={tag,2'b00}, mem_read=1, state REQ.
- REQ:
  - mem_read and mem_addr held stable until mem_ready=1.
  - On mem_ready, mem_read drops next cycle and state goes to WAIT.
  - mem_data_valid in the same cycle as mem_ready is allowed: treat as WAIT completion directly.
- WAIT, on mem_data_valid:
  - line_data=mem_data, line_tag=tag, line_valid=1.
  - Next cycle inst_valid=1 with the selected halfword; state IDLE.
  - Miss latency = 1 + bus wait + 1 cycles.
- flush:
  - Any state: suppresses inst_valid for the following cycle; no request accepted that cycle.
  - IDLE: no effect beyond the above.
  - REQ, mem_ready=0: drop mem_read next cycle, go IDLE.
  - REQ, mem_ready=1: go DROP.
  - WAIT: go DROP; if mem_data_valid arrives in the same cycle, the line is still filled but no inst_valid.
  - DROP: stay DROP.
- DROP:
  - On mem_data_valid, fill the line buffer (data is correct for its address), no inst_valid, go IDLE.
- Flush does not invalidate the line buffer; instruction memory is treated as read-only.
- mem_data_valid in IDLE or REQ (before acceptance) is ignored.
- Reset mid-operation:
  - Immediate IDLE, line_valid=0, mem_read=0.
  - A response arriving later is ignored, because IDLE ignores mem_data_valid.
- At most one bus read outstanding at any time.

Test Plan:
- Reset, then request 0x2000_0000, memory returns 0xBBBB_AAAA after 2 wait cycles -> mem_addr=0x2000_0000; inst_data=0xAAAA, inst_valid one cycle after mem_data_valid.
- Next request 0x2000_0002 -> hit, inst_data=0xBBBB one cycle later, mem_read stays 0.
- Request 0x2000_0004, mem_ready held low 3 cycles -> mem_read/mem_addr=0x2000_0004 stable all 4 cycles; fetch_ready=0 throughout.
- Miss to 0x2000_0010, flush asserted in WAIT, then data 0x1234_5678 -> no inst_valid; then request 0x2000_0012 -> hit, inst_data=0x1234.
- Flush in REQ with mem_ready=0 -> mem_read low next cycle, fetch_ready=1; a late mem_data_valid is ignored with no inst_valid and no line fill.
- Reset during WAIT, then request 0x2000_0000 -> treated as a miss (line_valid cleared), new mem_read issued.
